// File: rtl/vfu_mem_pkg.sv
// vfu_mem_pkg: shared IDs, arbiter state type and default widths for the memory arbiter
package vfu_mem_pkg;
    localparam logic REQ_VPU = 1'b0;
    localparam logic REQ_HOST = 1'b1;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int MAX_OUT_DEF = 4;
    typedef enum logic {ARB, HOLD} arb_state_e;
endpackage

// File: rtl/vfu_mem_arbiter_if.sv
// vfu_mem_arbiter_if: request/grant/response bundle used for both requester and memory sides
interface vfu_mem_arbiter_if
    import vfu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic req;
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic gnt;
    logic rvalid;
    logic [DATA_W-1:0] rdata;
    modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/vfu_id_fifo.sv
// vfu_id_fifo: synchronous FIFO of outstanding requester IDs; push and pop may coincide when full
module vfu_id_fifo #(
    parameter int W = 1,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic [W-1:0] din,
    input  logic pop,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] slots [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = slots[rd_ptr];
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    // Pointers wrap for free because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end
endmodule

// File: rtl/vfu_mem_arbiter.sv
// vfu_mem_arbiter: round-robin share of one memory port between the VPU and host, with in-order read routing
module vfu_mem_arbiter
    import vfu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    vfu_mem_arbiter_if.slave r0,
    vfu_mem_arbiter_if.slave r1,
    vfu_mem_arbiter_if.master mem,
    output logic err
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    arb_state_e state, state_nxt;
    logic last_win, lock_id, win, has_win, xfer, push, pop, pop_id;
    logic full, empty, room, elig0, elig1;
    logic [CW-1:0] count;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    vfu_id_fifo #(.W(1), .DEPTH(MAX_OUT)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din(win),
        .pop(pop),
        .dout(pop_id),
        .full(full),
        .empty(empty),
        .count(count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else state <= state_nxt;
    end

    always_comb state_nxt = state == ARB ? (has_win && !mem.gnt ? HOLD : ARB) : (xfer ? ARB : HOLD);

    // A response popping this cycle frees the slot a new read would take
    always_comb begin
        room = !full || mem.rvalid;
        elig0 = r0.req && (r0.we || room);
        elig1 = r1.req && (r1.we || room);
        win = state == HOLD ? lock_id : (elig0 && elig1 ? !last_win : elig1);
        has_win = state == HOLD ? (lock_id ? r1.req : r0.req) : (elig0 || elig1);
        addr_sel = win ? r1.addr : r0.addr;
        wdata_sel = win ? r1.wdata : r0.wdata;
        mem.req = has_win;
        mem.we = has_win && (win ? r1.we : r0.we);
        mem.addr = addr_sel;
        mem.wdata = wdata_sel;
        xfer = has_win && mem.gnt;
        r0.gnt = xfer && win == REQ_VPU;
        r1.gnt = xfer && win == REQ_HOST;
        push = xfer && !mem.we;
        pop = mem.rvalid && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= REQ_HOST;
            lock_id <= REQ_VPU;
        end else begin
            if (xfer) last_win <= win;
            if (state == ARB && has_win && !mem.gnt) lock_id <= win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0.rvalid <= 1'b0;
            r1.rvalid <= 1'b0;
            r0.rdata <= '0;
            r1.rdata <= '0;
            err <= 1'b0;
        end else begin
            r0.rvalid <= pop && pop_id == REQ_VPU;
            r1.rvalid <= pop && pop_id == REQ_HOST;
            if (pop && pop_id == REQ_VPU) r0.rdata <= mem.rdata;
            if (pop && pop_id == REQ_HOST) r1.rdata <= mem.rdata;
            if (mem.rvalid && count == '0 && !push) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vfu_mem_arbiter.sv
// tb_vfu_mem_arbiter: table-driven arbitration vectors plus directed multi-cycle sequences
module tb_vfu_mem_arbiter;
    typedef struct {
        logic q0, w0, q1, w1;
        logic e_req, e_we, e_g0, e_g1;
        logic [31:0] e_addr;
    } vec_t;

    localparam logic [63:0] W0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] DA5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] D5A = 64'h5A5A_5A5A_5A5A_5A5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int n_chk = 0;
    int n_fail = 0;
    vec_t vt[12];

    always #5 clk = ~clk;

    vfu_mem_arbiter_if r0_if ();
    vfu_mem_arbiter_if r1_if ();
    vfu_mem_arbiter_if mem_if ();

    vfu_mem_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .r0(r0_if),
        .r1(r1_if),
        .mem(mem_if),
        .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic q0, input logic w0, input logic q1, input logic w1);
        r0_if.req = q0;
        r0_if.we = w0;
        r1_if.req = q1;
        r1_if.we = w1;
    endtask

    task automatic set_mem(input logic g, input logic rv, input logic [63:0] rd);
        mem_if.gnt = g;
        mem_if.rvalid = rv;
        mem_if.rdata = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_req(0, 0, 0, 0);
        set_mem(0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g0_cnt, g1_cnt;
        vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[1] = '{1, 1, 0, 0, 1, 1, 1, 0, 32'h100};
        vt[2] = '{0, 0, 1, 1, 1, 1, 0, 1, 32'h200};
        vt[3] = '{1, 1, 1, 1, 1, 1, 1, 0, 32'h100};
        vt[4] = '{1, 1, 1, 1, 1, 1, 0, 1, 32'h200};
        vt[5] = '{1, 1, 1, 1, 1, 1, 1, 0, 32'h100};
        vt[6] = '{1, 1, 1, 1, 1, 1, 0, 1, 32'h200};
        vt[7] = '{1, 1, 1, 1, 1, 1, 1, 0, 32'h100};
        vt[8] = '{1, 1, 1, 1, 1, 1, 0, 1, 32'h200};
        vt[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 32'h100};
        vt[10] = '{1, 1, 1, 1, 1, 1, 0, 1, 32'h200};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        r0_if.addr = 32'h100;
        r1_if.addr = 32'h200;
        r0_if.wdata = W0;
        r1_if.wdata = W1;
        do_reset();
        #1;
        chk("rst_mem_req", mem_if.req, 0);
        chk("rst_mem_we", mem_if.we, 0);
        chk("rst_r0_gnt", r0_if.gnt, 0);
        chk("rst_r1_gnt", r1_if.gnt, 0);
        chk("rst_r0_rvalid", r0_if.rvalid, 0);
        chk("rst_r1_rvalid", r1_if.rvalid, 0);
        chk("rst_r0_rdata", r0_if.rdata, 0);
        chk("rst_r1_rdata", r1_if.rdata, 0);
        chk("rst_err", err, 0);

        // Table: writes only, memory always ready; rows 3..10 are the fairness run
        set_mem(1, 0, 0);
        g0_cnt = 0;
        g1_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            set_req(vt[i].q0, vt[i].w0, vt[i].q1, vt[i].w1);
            #1;
            chk($sformatf("vec%0d_mem_req", i), mem_if.req, vt[i].e_req);
            chk($sformatf("vec%0d_mem_we", i), mem_if.we, vt[i].e_we);
            chk($sformatf("vec%0d_r0_gnt", i), r0_if.gnt, vt[i].e_g0);
            chk($sformatf("vec%0d_r1_gnt", i), r1_if.gnt, vt[i].e_g1);
            chk($sformatf("vec%0d_rvalid", i), {r0_if.rvalid, r1_if.rvalid}, 0);
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d_addr", i), mem_if.addr, vt[i].e_addr);
                chk($sformatf("vec%0d_wdata", i), mem_if.wdata, vt[i].e_g1 ? W1 : W0);
            end
            if (i >= 3 && i <= 10) begin
                g0_cnt += int'(r0_if.gnt);
                g1_cnt += int'(r1_if.gnt);
            end
            tick();
        end
        chk("rr_r0_grants", g0_cnt, 4);
        chk("rr_r1_grants", g1_cnt, 4);

        // Tie after reset, 2-cycle read latency
        do_reset();
        set_mem(1, 0, 0);
        set_req(1, 0, 1, 0);
        #1;
        chk("tie_r0_gnt", r0_if.gnt, 1);
        chk("tie_r1_gnt_first", r1_if.gnt, 0);
        chk("tie_addr0", mem_if.addr, 32'h100);
        tick();
        set_req(0, 0, 1, 0);
        #1;
        chk("tie_r1_gnt", r1_if.gnt, 1);
        chk("tie_r0_gnt_second", r0_if.gnt, 0);
        chk("tie_addr1", mem_if.addr, 32'h200);
        tick();
        set_req(0, 0, 0, 0);
        set_mem(1, 1, DA5);
        #1;
        chk("tie_idle_req", mem_if.req, 0);
        tick();
        set_mem(1, 1, D5A);
        chk("tie_r0_rvalid", r0_if.rvalid, 1);
        chk("tie_r0_rdata", r0_if.rdata, DA5);
        chk("tie_r1_rvalid_early", r1_if.rvalid, 0);
        tick();
        set_mem(1, 0, 0);
        chk("tie_r1_rvalid", r1_if.rvalid, 1);
        chk("tie_r1_rdata", r1_if.rdata, D5A);
        chk("tie_r0_rvalid_off", r0_if.rvalid, 0);
        chk("tie_r0_rdata_hold", r0_if.rdata, DA5);
        tick();
        chk("tie_rvalid_done", {r0_if.rvalid, r1_if.rvalid}, 0);
        chk("tie_err", err, 0);

        // Stall lock: r1 holds the port through a stall even once r0 requests
        do_reset();
        chk("rst2_r0_rdata", r0_if.rdata, 0);
        chk("rst2_r1_rdata", r1_if.rdata, 0);
        set_mem(0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            set_req(c >= 2, 0, 1, 0);
            #1;
            chk($sformatf("stall_c%0d_req", c), mem_if.req, 1);
            chk($sformatf("stall_c%0d_addr", c), mem_if.addr, 32'h200);
            chk($sformatf("stall_c%0d_gnt", c), {r0_if.gnt, r1_if.gnt}, 0);
            tick();
        end
        set_mem(1, 0, 0);
        #1;
        chk("stall_r1_gnt", r1_if.gnt, 1);
        chk("stall_r0_wait", r0_if.gnt, 0);
        chk("stall_rel_addr", mem_if.addr, 32'h200);
        tick();
        set_req(1, 0, 0, 0);
        #1;
        chk("stall_r0_gnt", r0_if.gnt, 1);
        chk("stall_r0_addr", mem_if.addr, 32'h100);
        tick();
        set_req(0, 0, 0, 0);
        set_mem(0, 1, 64'hB1);
        tick();
        set_mem(0, 1, 64'hB0);
        chk("stall_r1_rvalid", r1_if.rvalid, 1);
        chk("stall_r1_rdata", r1_if.rdata, 64'hB1);
        chk("stall_r0_rvalid_early", r0_if.rvalid, 0);
        tick();
        set_mem(0, 0, 0);
        chk("stall_r0_rvalid", r0_if.rvalid, 1);
        chk("stall_r0_rdata", r0_if.rdata, 64'hB0);
        tick();

        // Outstanding limit, full push/pop and pointer wrap
        do_reset();
        r0_if.addr = 32'h300;
        set_mem(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            set_req(1, 0, 0, 0);
            #1;
            chk($sformatf("lim_read%0d_gnt", k), r0_if.gnt, 1);
            tick();
        end
        set_req(1, 0, 1, 1);
        #1;
        chk("lim_full_req", mem_if.req, 1);
        chk("lim_full_we", mem_if.we, 1);
        chk("lim_full_r1_gnt", r1_if.gnt, 1);
        chk("lim_full_r0_gnt", r0_if.gnt, 0);
        chk("lim_full_addr", mem_if.addr, 32'h200);
        tick();
        set_req(1, 0, 0, 0);
        #1;
        chk("lim_blocked_req", mem_if.req, 0);
        chk("lim_blocked_gnt", r0_if.gnt, 0);
        tick();
        set_mem(1, 1, 64'hD0);
        #1;
        chk("lim_pushpop_req", mem_if.req, 1);
        chk("lim_pushpop_gnt", r0_if.gnt, 1);
        tick();
        set_req(0, 0, 1, 0);
        set_mem(1, 0, 0);
        #1;
        chk("lim_still_full_req", mem_if.req, 0);
        chk("lim_still_full_gnt", r1_if.gnt, 0);
        chk("lim_d0_rvalid", r0_if.rvalid, 1);
        chk("lim_d0_rdata", r0_if.rdata, 64'hD0);
        tick();
        set_mem(1, 1, 64'hD1);
        #1;
        chk("lim_wrap_r1_gnt", r1_if.gnt, 1);
        tick();
        set_req(0, 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            set_mem(1, 1, 64'hD0 + 64'(k));
            chk($sformatf("lim_d%0d_r0_rvalid", k - 1), r0_if.rvalid, 1);
            chk($sformatf("lim_d%0d_r0_rdata", k - 1), r0_if.rdata, 64'hD0 + 64'(k - 1));
            chk($sformatf("lim_d%0d_r1_rvalid", k - 1), r1_if.rvalid, 0);
            tick();
        end
        set_mem(1, 0, 0);
        chk("lim_d5_r1_rvalid", r1_if.rvalid, 1);
        chk("lim_d5_r1_rdata", r1_if.rdata, 64'hD5);
        chk("lim_d5_r0_rvalid", r0_if.rvalid, 0);
        tick();
        chk("lim_err", err, 0);

        // Error: reset flushes outstanding reads, stale responses flag err
        do_reset();
        r0_if.addr = 32'h100;
        set_mem(1, 0, 0);
        set_req(1, 0, 0, 0);
        #1;
        chk("err_read0_gnt", r0_if.gnt, 1);
        tick();
        #1;
        chk("err_read1_gnt", r0_if.gnt, 1);
        tick();
        set_req(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("err_in_reset", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_mem(0, 1, 64'hEE);
        for (int p = 0; p < 2; p++) begin
            tick();
            chk($sformatf("err_stale%0d_rvalid", p), {r0_if.rvalid, r1_if.rvalid}, 0);
            chk($sformatf("err_stale%0d_err", p), err, 1);
        end
        set_mem(0, 0, 0);
        repeat (3) tick();
        chk("err_sticky", err, 1);
        chk("err_no_rvalid", {r0_if.rvalid, r1_if.rvalid}, 0);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("err_after_reset", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
